amci_arbiter: RTL and testbench

- Shares one AMCI-style AXI4-Lite master engine (write FSM plus read FSM) between NUM_REQ independent client state machines (button sequencer, config loaders, status pollers).
- Clients post single-beat read or write requests. The arbiter grants them round-robin, runs one transaction at a time on the engine, and returns the response to the granted client only.
- Sits between client logic and the AXI master FSMs inside the controller.

---
 rtl/amci_arbiter_if.sv | 41 ++++
 rtl/amci_arbiter.sv | 141 ++++++++++++++
 tb/tb_amci_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amci_arbiter_if.sv
// Client request/response and engine start/complete bundle for amci_arbiter.
// The master view is the arbiter; the slave view is the clients plus the AXI engine.
interface amci_arbiter_if #(
   parameter int NUM_REQ        = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]                REQ_VALID;
   logic [NUM_REQ-1:0]                REQ_WRITE;
   logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] REQ_ADDR;
   logic [NUM_REQ*AXI_DATA_WIDTH-1:0] REQ_WDATA;
   logic [NUM_REQ-1:0]                REQ_READY;
   logic [NUM_REQ-1:0]                RSP_VALID;
   logic [AXI_DATA_WIDTH-1:0]         RSP_RDATA;
   logic [1:0]                        RSP_RESP;
   logic                              BUSY;
   logic [2:0]                        GRANT_ID;
   logic [AXI_ADDR_WIDTH-1:0]         ENG_ADDR;
   logic [AXI_DATA_WIDTH-1:0]         ENG_WDATA;
   logic                              ENG_WRITE;
   logic                              ENG_READ;
   logic                              ENG_WIDLE;
   logic                              ENG_RIDLE;
   logic [1:0]                        ENG_WRESP;
   logic [AXI_DATA_WIDTH-1:0]         ENG_RDATA;
   logic [1:0]                        ENG_RRESP;

   modport master (
      input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      input  ENG_WIDLE, ENG_RIDLE, ENG_WRESP, ENG_RDATA, ENG_RRESP,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP, BUSY, GRANT_ID,
      output ENG_ADDR, ENG_WDATA, ENG_WRITE, ENG_READ
   );

   modport slave (
      output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      output ENG_WIDLE, ENG_RIDLE, ENG_WRESP, ENG_RDATA, ENG_RRESP,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP, BUSY, GRANT_ID,
      input  ENG_ADDR, ENG_WDATA, ENG_WRITE, ENG_READ
   );
endinterface

// File: rtl/amci_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4-Lite master engine between
// NUM_REQ client state machines; one transaction in flight, fully registered outputs.
module amci_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
) (
   input logic            M_AXI_ACLK,
   input logic            M_AXI_ARESET,
   amci_arbiter_if.master bus
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t                    state_q, state_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [2:0]                grant_q, grant_d;
   logic                      write_q, write_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                resp_q, resp_d;
   logic                      busy_q, busy_d;
   logic                      eng_write_q, eng_write_d;
   logic                      eng_read_q, eng_read_d;

   logic                      found;
   logic [PW-1:0]             gsel;

   // Scan upward from the slot after the last grant so the served client ranks last.
   always_comb begin
      found = 1'b0;
      gsel  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && bus.REQ_VALID[(int'(ptr_q) + k) % NUM_REQ]) begin
            found = 1'b1;
            gsel  = PW'((int'(ptr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      // NOTE: every _d takes its hold value first so no path through the case infers a latch.
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      busy_d      = busy_q;
      eng_write_d = 1'b0;
      eng_read_d  = 1'b0;

      case (state_q)
         ST_WAIT: begin
            // Idle flags are stale during the start-pulse cycle, so skip it.
            if (!(eng_write_q || eng_read_q)) begin
               if (write_q && bus.ENG_WIDLE) begin
                  resp_d      = bus.ENG_WRESP;
                  rdata_d     = '0;
                  rsp_valid_d = NUM_REQ'(1) << grant_q;
                  state_d     = ST_RESP;
               end else if (!write_q && bus.ENG_RIDLE) begin
                  resp_d      = bus.ENG_RRESP;
                  rdata_d     = bus.ENG_RDATA;
                  rsp_valid_d = NUM_REQ'(1) << grant_q;
                  state_d     = ST_RESP;
               end
            end
         end
         default: begin
            // IDLE and RESP both arbitrate, so a waiting client is granted right after RSP_VALID.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (found) begin
               state_d     = ST_WAIT;
               busy_d      = 1'b1;
               ptr_d       = gsel;
               grant_d     = 3'(gsel);
               write_d     = bus.REQ_WRITE[gsel];
               addr_d      = bus.REQ_ADDR[int'(gsel)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
               wdata_d     = bus.REQ_WDATA[int'(gsel)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
               req_ready_d = NUM_REQ'(1) << gsel;
               eng_write_d = bus.REQ_WRITE[gsel];
               eng_read_d  = !bus.REQ_WRITE[gsel];
            end
         end
      endcase
   end

   // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state_q     <= ST_IDLE;
         ptr_q       <= PW'(NUM_REQ - 1);
         grant_q     <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rdata_q     <= '0;
         resp_q      <= '0;
         busy_q      <= 1'b0;
         eng_write_q <= 1'b0;
         eng_read_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         busy_q      <= busy_d;
         eng_write_q <= eng_write_d;
         eng_read_q  <= eng_read_d;
      end
   end

   assign bus.REQ_READY = req_ready_q;
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_RDATA = rdata_q;
   assign bus.RSP_RESP  = resp_q;
   assign bus.BUSY      = busy_q;
   assign bus.GRANT_ID  = grant_q;
   assign bus.ENG_ADDR  = addr_q;
   assign bus.ENG_WDATA = wdata_q;
   assign bus.ENG_WRITE = eng_write_q;
   assign bus.ENG_READ  = eng_read_q;
endmodule

// File: tb/tb_amci_arbiter.sv
// Directed bench for amci_arbiter: a latency-programmable engine model, a passive
// monitor logging grants/responses, and one task per scenario with inline checks.
module tb_amci_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   amci_arbiter_if #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

   amci_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
      .M_AXI_ACLK  (clk),
      .M_AXI_ARESET(rst),
      .bus         (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Engine model: idle drops the cycle after a start pulse and returns after lat cycles;
   // lat = 0 models an engine whose idle flag never drops.
   int   wlat = 0, rlat = 0, wcnt = 0, rcnt = 0;
   logic widle = 1'b1, ridle = 1'b1;
   assign bus.ENG_WIDLE = widle;
   assign bus.ENG_RIDLE = ridle;

   always @(posedge clk) begin
      if (rst) begin
         widle <= 1'b1; ridle <= 1'b1; wcnt <= 0; rcnt <= 0;
      end else begin
         if (bus.ENG_WRITE && wlat > 0) begin
            widle <= 1'b0; wcnt <= wlat;
         end else if (!widle) begin
            if (wcnt <= 1) widle <= 1'b1;
            wcnt <= wcnt - 1;
         end
         if (bus.ENG_READ && rlat > 0) begin
            ridle <= 1'b0; rcnt <= rlat;
         end else if (!ridle) begin
            if (rcnt <= 1) ridle <= 1'b1;
            rcnt <= rcnt - 1;
         end
      end
   end

   // Passive monitor, sampled on the falling edge.
   int              cyc = 0, wpulse = 0, rpulse = 0;
   bit              overlap = 1'b0;
   int              grant_log[$];
   int              grant_cyc[$];
   int              rsp_cyc[$];
   logic [N-1:0]    ready_log[$];
   logic [AW-1:0]   addr_log[$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (|bus.REQ_READY) begin
         grant_log.push_back(int'(bus.GRANT_ID));
         ready_log.push_back(bus.REQ_READY);
         addr_log.push_back(bus.ENG_ADDR);
         grant_cyc.push_back(cyc + 1);
      end
      if (bus.ENG_WRITE) wpulse <= wpulse + 1;
      if (bus.ENG_READ)  rpulse <= rpulse + 1;
      if ((bus.ENG_WRITE && bus.ENG_READ) ||
          ((bus.ENG_WRITE || bus.ENG_READ) && !(widle && ridle))) overlap <= 1'b1;
      if (|bus.RSP_VALID) rsp_cyc.push_back(cyc + 1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.REQ_WRITE[i]           = wr;
      bus.REQ_ADDR[i*AW +: AW]   = a;
      bus.REQ_WDATA[i*DW +: DW]  = d;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 64; k++) begin
         tick();
         if (|bus.REQ_READY) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 64; k++) begin
         tick();
         if (|bus.RSP_VALID) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_count(input bit rsp, input int base, input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (((rsp ? rsp_cyc.size() : grant_log.size()) - base) >= n) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++; if (bus.REQ_READY !== '0) begin failures++; $display("FAIL %s_ready got=%b exp=0", tag, bus.REQ_READY); end
      checks++; if (bus.RSP_VALID !== '0) begin failures++; $display("FAIL %s_rsp_valid got=%b exp=0", tag, bus.RSP_VALID); end
      checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL %s_busy got=%b exp=0", tag, bus.BUSY); end
      checks++; if (bus.GRANT_ID !== 3'd0) begin failures++; $display("FAIL %s_grant_id got=%0d exp=0", tag, bus.GRANT_ID); end
      checks++; if ({bus.ENG_WRITE, bus.ENG_READ} !== 2'b00) begin failures++; $display("FAIL %s_eng_pulse got=%b exp=00", tag, {bus.ENG_WRITE, bus.ENG_READ}); end
      checks++; if (bus.RSP_RDATA !== '0) begin failures++; $display("FAIL %s_rdata got=%h exp=0", tag, bus.RSP_RDATA); end
      checks++; if (bus.RSP_RESP !== 2'b00) begin failures++; $display("FAIL %s_resp got=%b exp=00", tag, bus.RSP_RESP); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      bit ok; int t0, r0;
      rlat = 0; bus.ENG_RDATA = 32'hDEAD_BEEF; bus.ENG_RRESP = 2'b00;
      set_req(0, 1'b0, 32'hC000_0000, 32'h0);
      t0 = cyc; r0 = rpulse;
      bus.REQ_VALID = 4'b0001;
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rd_ready_timeout got=0 exp=1"); end
      checks++; if (bus.REQ_READY !== 4'b0001) begin failures++; $display("FAIL rd_ready got=%b exp=0001", bus.REQ_READY); end
      checks++; if ({bus.ENG_READ, bus.ENG_WRITE} !== 2'b10) begin failures++; $display("FAIL rd_eng_pulse got=%b exp=10", {bus.ENG_READ, bus.ENG_WRITE}); end
      checks++; if (bus.ENG_ADDR !== 32'hC000_0000) begin failures++; $display("FAIL rd_addr got=%h exp=c0000000", bus.ENG_ADDR); end
      checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL rd_busy got=%b exp=1", bus.BUSY); end
      bus.REQ_VALID = 4'b0000;
      wait_rsp(ok);
      checks++; if (bus.RSP_VALID !== 4'b0001) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=0001", bus.RSP_VALID); end
      checks++; if (bus.RSP_RDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", bus.RSP_RDATA); end
      checks++; if (bus.RSP_RESP !== 2'b00) begin failures++; $display("FAIL rd_resp got=%b exp=00", bus.RSP_RESP); end
      checks++; if (cyc - t0 != 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", cyc - t0); end
      checks++; if (rpulse - r0 != 1) begin failures++; $display("FAIL rd_pulses got=%0d exp=1", rpulse - r0); end
      tick();
   endtask

   task automatic test_single_write();
      bit ok; int w0;
      wlat = 5; bus.ENG_WRESP = 2'b00;
      set_req(2, 1'b1, 32'h0000_1014, 32'h42);
      w0 = wpulse;
      bus.REQ_VALID = 4'b0100;
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL wr_ready_timeout got=0 exp=1"); end
      checks++; if (bus.REQ_READY !== 4'b0100) begin failures++; $display("FAIL wr_ready got=%b exp=0100", bus.REQ_READY); end
      checks++; if ({bus.ENG_WRITE, bus.ENG_READ} !== 2'b10) begin failures++; $display("FAIL wr_eng_pulse got=%b exp=10", {bus.ENG_WRITE, bus.ENG_READ}); end
      checks++; if (bus.ENG_ADDR !== 32'h0000_1014) begin failures++; $display("FAIL wr_addr got=%h exp=00001014", bus.ENG_ADDR); end
      checks++; if (bus.ENG_WDATA !== 32'h42) begin failures++; $display("FAIL wr_wdata got=%h exp=00000042", bus.ENG_WDATA); end
      checks++; if (bus.GRANT_ID !== 3'd2) begin failures++; $display("FAIL wr_grant_id got=%0d exp=2", bus.GRANT_ID); end
      bus.REQ_VALID = 4'b0000;
      wait_rsp(ok);
      checks++; if (bus.RSP_VALID !== 4'b0100) begin failures++; $display("FAIL wr_rsp_valid got=%b exp=0100", bus.RSP_VALID); end
      checks++; if (bus.RSP_RESP !== 2'b00) begin failures++; $display("FAIL wr_resp got=%b exp=00", bus.RSP_RESP); end
      checks++; if (bus.RSP_RDATA !== '0) begin failures++; $display("FAIL wr_rdata got=%h exp=0", bus.RSP_RDATA); end
      checks++; if (wpulse - w0 != 1) begin failures++; $display("FAIL wr_pulses got=%0d exp=1", wpulse - w0); end
      tick();
      checks++; if ({bus.BUSY, |bus.RSP_VALID} !== 2'b00) begin failures++; $display("FAIL wr_after_rsp got=%b exp=00", {bus.BUSY, |bus.RSP_VALID}); end
   endtask

   task automatic test_round_robin();
      bit ok; int gb, rb, r0;
      rst = 1'b1; tick(); rst = 1'b0; tick();
      rlat = 2; bus.ENG_RDATA = 32'h0BAD_F00D; bus.ENG_RRESP = 2'b00;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 + 32'(4*i), 32'h0);
      gb = grant_log.size(); rb = rsp_cyc.size(); r0 = rpulse;
      bus.REQ_VALID = 4'b1111;
      wait_count(1'b0, gb, 8, ok);
      bus.REQ_VALID = 4'b0000;
      checks++; if (!ok) begin failures++; $display("FAIL rr_grant_timeout got=%0d exp=8", grant_log.size() - gb); end
      wait_count(1'b1, rb, 8, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_rsp_timeout got=%0d exp=8", rsp_cyc.size() - rb); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (grant_log[gb+i] != i % 4) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grant_log[gb+i], i % 4); end
         checks++; if (ready_log[gb+i] !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_ready%0d got=%b exp=%b", i, ready_log[gb+i], 4'(1 << (i % 4))); end
         checks++; if (addr_log[gb+i] !== 32'h100 + 32'(4*(i % 4))) begin failures++; $display("FAIL rr_addr%0d got=%h exp=%h", i, addr_log[gb+i], 32'h100 + 32'(4*(i % 4))); end
      end
      checks++; if (rpulse - r0 != 8) begin failures++; $display("FAIL rr_pulses got=%0d exp=8", rpulse - r0); end
      checks++; if (overlap) begin failures++; $display("FAIL rr_overlap got=1 exp=0"); end
      checks++; if (grant_cyc[gb+1] != rsp_cyc[rb] + 1) begin failures++; $display("FAIL rr_regrant_gap got=%0d exp=%0d", grant_cyc[gb+1], rsp_cyc[rb] + 1); end
      tick();
   endtask

   task automatic test_fairness();
      bit ok; int gb, rb;
      int exp_seq[4] = '{3, 1, 3, 1};
      rlat = 1;
      set_req(1, 1'b0, 32'h2000, 32'h0);
      set_req(3, 1'b0, 32'h3000, 32'h0);
      bus.REQ_VALID = 4'b0010;
      wait_ready(ok);
      checks++; if (bus.GRANT_ID !== 3'd1) begin failures++; $display("FAIL fair_first got=%0d exp=1", bus.GRANT_ID); end
      bus.REQ_VALID = 4'b0000;
      wait_rsp(ok);
      gb = grant_log.size(); rb = rsp_cyc.size();
      bus.REQ_VALID = 4'b1010;
      wait_count(1'b0, gb, 4, ok);
      bus.REQ_VALID = 4'b0000;
      checks++; if (!ok) begin failures++; $display("FAIL fair_timeout got=%0d exp=4", grant_log.size() - gb); end
      wait_count(1'b1, rb, 4, ok);
      for (int i = 0; i < 4; i++) begin
         checks++; if (grant_log[gb+i] != exp_seq[i]) begin failures++; $display("FAIL fair_grant%0d got=%0d exp=%0d", i, grant_log[gb+i], exp_seq[i]); end
      end
      tick();
   endtask

   task automatic test_error();
      bit ok;
      rlat = 2; bus.ENG_RRESP = 2'b10; bus.ENG_RDATA = 32'h1234_5678;
      set_req(1, 1'b0, 32'h4000, 32'h0);
      bus.REQ_VALID = 4'b0010;
      wait_ready(ok);
      bus.REQ_VALID = 4'b0000;
      wait_rsp(ok);
      checks++; if (bus.RSP_VALID !== 4'b0010) begin failures++; $display("FAIL err_rsp_valid got=%b exp=0010", bus.RSP_VALID); end
      checks++; if (bus.RSP_RESP !== 2'b10) begin failures++; $display("FAIL err_rresp got=%b exp=10", bus.RSP_RESP); end
      checks++; if (bus.RSP_RDATA !== 32'h1234_5678) begin failures++; $display("FAIL err_rdata got=%h exp=12345678", bus.RSP_RDATA); end
      bus.ENG_RRESP = 2'b00; bus.ENG_WRESP = 2'b11; wlat = 1;
      set_req(0, 1'b1, 32'h20, 32'h5);
      bus.REQ_VALID = 4'b0001;
      wait_ready(ok);
      checks++; if (!ok || bus.GRANT_ID !== 3'd0) begin failures++; $display("FAIL err_next_grant got=%0d exp=0", bus.GRANT_ID); end
      bus.REQ_VALID = 4'b0000;
      wait_rsp(ok);
      checks++; if (bus.RSP_VALID !== 4'b0001) begin failures++; $display("FAIL err_next_valid got=%b exp=0001", bus.RSP_VALID); end
      checks++; if (bus.RSP_RESP !== 2'b11) begin failures++; $display("FAIL err_bresp got=%b exp=11", bus.RSP_RESP); end
      checks++; if (bus.RSP_RDATA !== '0) begin failures++; $display("FAIL err_wr_rdata got=%h exp=0", bus.RSP_RDATA); end
      tick();
   endtask

   task automatic test_reset_mid_op();
      bit ok; int rc, gb, rb;
      wlat = 10;
      set_req(2, 1'b1, 32'h5000, 32'h77);
      bus.REQ_VALID = 4'b0100;
      wait_ready(ok);
      bus.REQ_VALID = 4'b0000;
      tick(); tick();
      checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", bus.BUSY); end
      rc = rsp_cyc.size();
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      checks++; if (rsp_cyc.size() != rc) begin failures++; $display("FAIL mid_orphan_rsp got=%0d exp=%0d", rsp_cyc.size(), rc); end
      rlat = 1; bus.ENG_RDATA = 32'hCAFE_0003;
      set_req(1, 1'b0, 32'h6000, 32'h0);
      set_req(3, 1'b0, 32'h7000, 32'h0);
      gb = grant_log.size(); rb = rsp_cyc.size();
      bus.REQ_VALID = 4'b1010;
      wait_count(1'b0, gb, 2, ok);
      bus.REQ_VALID = 4'b0000;
      wait_count(1'b1, rb, 2, ok);
      checks++; if (!ok) begin failures++; $display("FAIL mid_post_timeout got=%0d exp=2", rsp_cyc.size() - rb); end
      checks++; if (grant_log[gb] != 1) begin failures++; $display("FAIL mid_post_grant0 got=%0d exp=1", grant_log[gb]); end
      checks++; if (grant_log[gb+1] != 3) begin failures++; $display("FAIL mid_post_grant1 got=%0d exp=3", grant_log[gb+1]); end
      tick();
   endtask

   initial begin
      bus.REQ_VALID = '0; bus.REQ_WRITE = '0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
      bus.ENG_WRESP = 2'b00; bus.ENG_RDATA = '0; bus.ENG_RRESP = 2'b00;
      test_reset();
      test_single_read();
      test_single_write();
      test_round_robin();
      test_fairness();
      test_error();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
